issue_scoreboard: RTL
=====================

# issue_scoreboard

Register scoreboard and issue gate between decode and data-fetch in the core pipeline. It tracks pending writes to each architectural GPR and decides each cycle whether the decoded micro-op may issue. Pending counts are incremented on issue and decremented on writeback. It supports micro-ops with two destinations (a stack op writes both a data register and RSP), pipeline flush, and sticky error reporting.

## Interface
Parameters:
- NREGS, 17: number of tracked registers; indices 0..NREGS-1.
- RIDXW, 5: register index width.
- CNTW, 2: per-register pending-write counter width; max count is 2^CNTW-1.
- INFW, 8: width of the total in-flight counter.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  synchronous reset, active-low.
- iss_valid  in  1  decode presents a micro-op.
- iss_src_valid  in  3  per-source valid, bits 0..2.
- iss_src0, iss_src1, iss_src2  in  RIDXW  source register indices.
- iss_dst_valid  in  2  per-destination valid, bits 0..1.
- iss_dst0, iss_dst1  in  RIDXW  destination indices.
- stall  in  1  downstream blocked (memory stage busy).
- iss_ready  out  1  micro-op may issue this cycle.
- iss_fire  out  1  iss_valid & iss_ready.
- wb_valid  in  2  per-port writeback valid.
- wb_reg0, wb_reg1  in  RIDXW  writeback register indices.
- flush  in  1  discard all pending writes.
- busy_mask  out  NREGS  bit i set when count[i] != 0.
- inflight  out  INFW  sum of all counts.
- err_underflow  out  1  sticky; writeback to a register whose count is 0.
- err_overflow  out  1  sticky; fire would exceed max count. This is unreachable when the design is correct.

## Operation
- State:
  - count[NREGS] of CNTW bits each.
  - inflight register.
  - two sticky error bits.
- Out-of-range index (>= NREGS): ignored for hazard checks, increments and decrements.
- Hazard rules, evaluated on current (pre-edge) counts:
  - RAW: any valid source with count != 0 blocks issue.
  - Destination saturation: any valid destination with count == max blocks issue.
  - WAW below saturation is allowed.
- No same-cycle bypass: a writeback in cycle N does not unblock a source check in cycle N. The register file writes on the same edge.
- iss_ready = !flush & !stall & no hazard. iss_ready is computed even when iss_valid = 0. iss_fire requires iss_valid.
- Increment on iss_fire, one per valid destination:
  - iss_dst0 == iss_dst1 with both valid counts as a single increment.
- Decrement per valid writeback port:
  - wb_reg0 == wb_reg1 with both valid counts as a single decrement.
- Net update per register = increments - decrements in the same cycle. Issue and writeback to the same register in one cycle leaves the count unchanged.
- Underflow: decrement of a zero count leaves the count at 0 and sets err_underflow. It does not apply when a same-cycle increment to that register covers it.
- inflight is updated by (number of effective increments) - (number of effective decrements). It is always equal to the sum of the counts.
- Flush: all counts and inflight go to 0 on the next edge. Flush overrides same-cycle fire and writeback, and iss_fire = 0 during flush. Error bits are unaffected.
- Reset: all counts, inflight, err_underflow and err_overflow = 0. busy_mask is then 0 and iss_ready is 1 (given no stall or flush).

## Timing
- iss_ready and iss_fire are combinational from the inputs and the registered counts. No added latency.
- Counts, inflight and error bits update at posedge clk. busy_mask is combinational from the counts.
- RAW turnaround: consider a destination issued at edge E and written back in cycle W. The dependent source sees iss_ready = 1 in cycle W+1.
- Reset is synchronous. reset_n low at an edge overrides flush, fire and writeback. Outputs take their reset values from that edge on, including mid-stream.
- Throughput: one issue and two writebacks per cycle.

## Test plan
- Reset then idle: busy_mask = 0, inflight = 0, iss_ready = 1. Assert reset_n low mid-traffic with counts nonzero: next cycle all are zero.
- RAW: fire with dst0 = 3. Next cycle, src0 = 3 gives iss_ready = 0. Write back r3 in cycle W: iss_ready = 1 in cycle W+1 and busy_mask[3] = 0.
- Saturation: three fires with dst0 = 5 (CNTW = 2) give count 3. A fourth with dst0 = 5 gives iss_ready = 0. One writeback to r5 reopens issue and inflight = 2.
- Simultaneous: count[7] = 1, fire with dst0 = 7 plus wb_reg0 = 7 in the same cycle gives count[7] = 1 and inflight unchanged. A stack op with dst0 = 4 and dst1 = 4 raises the count by 1 only.
- Underflow: writeback to r9 with count 0 gives err_underflow = 1, which persists through a flush. count[9] stays 0.
- Flush: counts at r1 = 2 and r2 = 1, flush asserted together with iss_valid, a ready micro-op and wb_reg0 = 1. Result: iss_fire = 0, then next cycle all counts = 0, inflight = 0, busy_mask = 0.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue gate: tracks pending GPR writes and decides each
// cycle whether the decoded micro-op may issue to data-fetch.
module issue_scoreboard #(
  parameter int NREGS = 17,
  parameter int RIDXW = 5,
  parameter int CNTW  = 2,
  parameter int INFW  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             iss_valid,
  input  logic [2:0]       iss_src_valid,
  input  logic [RIDXW-1:0] iss_src0,
  input  logic [RIDXW-1:0] iss_src1,
  input  logic [RIDXW-1:0] iss_src2,
  input  logic [1:0]       iss_dst_valid,
  input  logic [RIDXW-1:0] iss_dst0,
  input  logic [RIDXW-1:0] iss_dst1,
  input  logic             stall,
  output logic             iss_ready,
  output logic             iss_fire,
  input  logic [1:0]       wb_valid,
  input  logic [RIDXW-1:0] wb_reg0,
  input  logic [RIDXW-1:0] wb_reg1,
  input  logic             flush,
  output logic [NREGS-1:0] busy_mask,
  output logic [INFW-1:0]  inflight,
  output logic             err_underflow,
  output logic             err_overflow
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0]  count      [NREGS];
  logic [CNTW-1:0]  count_next [NREGS];
  logic [NREGS-1:0] src_hit;
  logic [NREGS-1:0] dst_hit;
  logic [NREGS-1:0] dec;
  logic             hazard;
  logic [INFW-1:0]  n_up;
  logic [INFW-1:0]  n_dn;
  logic             underflow;
  logic             overflow;

  // Index decode compares against each in-range register number, so indices
  // >= NREGS never match anything and are ignored without extra logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    src_hit = '0;
    dst_hit = '0;
    dec     = '0;
    hazard  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      src_hit[i] = (iss_src_valid[0] && iss_src0 == RIDXW'(i)) ||
                   (iss_src_valid[1] && iss_src1 == RIDXW'(i)) ||
                   (iss_src_valid[2] && iss_src2 == RIDXW'(i));
      dst_hit[i] = (iss_dst_valid[0] && iss_dst0 == RIDXW'(i)) ||
                   (iss_dst_valid[1] && iss_dst1 == RIDXW'(i));
      dec[i]     = (wb_valid[0] && wb_reg0 == RIDXW'(i)) ||
                   (wb_valid[1] && wb_reg1 == RIDXW'(i));
      if (src_hit[i] && count[i] != '0)    hazard = 1'b1;
      if (dst_hit[i] && count[i] == CNT_MAX) hazard = 1'b1;
    end
  end

  assign iss_ready = !flush && !stall && !hazard;
  assign iss_fire  = iss_valid && iss_ready;

  // An increment and a decrement to the same register cancel, which also keeps
  // a zero count from reporting underflow when the issue covers the writeback.
  always_comb begin
    n_up      = '0;
    n_dn      = '0;
    underflow = 1'b0;
    overflow  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      count_next[i] = count[i];
      unique case ({iss_fire && dst_hit[i], dec[i]})
        2'b10: begin
          if (count[i] == CNT_MAX) overflow = 1'b1;
          else begin
            count_next[i] = count[i] + CNTW'(1);
            n_up          = n_up + INFW'(1);
          end
        end
        2'b01: begin
          if (count[i] == '0) underflow = 1'b1;
          else begin
            count_next[i] = count[i] - CNTW'(1);
            n_dn          = n_dn + INFW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the counts are control state, not storage, so each one is reset explicitly.
      for (int i = 0; i < NREGS; i++) count[i] <= '0;
      inflight      <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NREGS; i++) count[i] <= '0;
      inflight <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) count[i] <= count_next[i];
      inflight      <= inflight + n_up - n_dn;
      err_underflow <= err_underflow | underflow;
      err_overflow  <= err_overflow | overflow;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NREGS; i++) busy_mask[i] = (count[i] != '0);
  end

endmodule
